// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Program loader for the single-cycle RISC-V core. Accepts a byte stream over
// a valid/ready handshake, assembles little-endian 32-bit instruction words and
// writes each one through the instruction memory write port. The CPU is held
// in reset until a complete image with a matching checksum is resident.
//
// Stream format:
//   N[7:0], N[15:8]                 word count
//   4*N payload bytes               least-significant byte of each word first
//   checksum                        sum of all payload bytes mod 256
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   clear      in   synchronous active-high reset, overrides everything
//   start      in   pulse that begins a load (honoured in IDLE, DONE, ERR)
//   rx_data    in   byte from the host stream
//   rx_valid   in   rx_data is valid
//   rx_ready   out  loader accepts a byte this cycle (registered)
//   we         out  instruction memory write strobe, one cycle per word
//   waddr      out  word address of the write
//   wdata      out  instruction word
//   cpu_hold   out  holds the CPU in reset; low only in DONE
//   done       out  image loaded and checksum matched (sticky)
//   error      out  length overflow or checksum mismatch (sticky)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t            state_q,    state_d;
    logic [15:0]       n_q,        n_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [7:0]        csum_q,     csum_d;
    logic [23:0]       asm_q,      asm_d;      // lanes 0..2; lane 3 comes straight from rx_data
    logic [31:0]       wdata_q,    wdata_d;
    logic [ADDR_W-1:0] waddr_q,    waddr_d;
    logic              we_q,       we_d;
    logic              rx_ready_q, rx_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q,     done_d;
    logic              error_q,    error_d;

    logic              xfer;
    logic [15:0]       len_in;

    // rx_ready_q always mirrors the receiving states, so this is the handshake
    assign xfer   = rx_valid && rx_ready_q;
    assign len_in = {rx_data, n_q[7:0]};

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        we_d       = 1'b0;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    csum_d     = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end

            LEN0: begin
                if (xfer) begin
                    n_d[7:0] = rx_data;
                    state_d  = LEN1;
                end
            end

            LEN1: begin
                if (xfer) begin
                    n_d[15:8] = rx_data;
                    if (len_in > DEPTH_W) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else if (len_in == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (xfer) begin
                    csum_d     = csum_q + rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            // Word is complete: hand it to a separate output
                            // register so assembly of the next word can proceed
                            // during the write cycle.
                            wdata_d    = {rx_data, asm_q};
                            waddr_d    = word_cnt_q[ADDR_W-1:0];
                            we_d       = 1'b1;
                            word_cnt_d = word_cnt_q + 16'd1;
                            if (word_cnt_d == n_q) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                end
            end

            CSUM: begin
                if (xfer) begin
                    if (rx_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it
        rx_ready_d = (state_d == LEN0) || (state_d == LEN1) ||
                     (state_d == DATA) || (state_d == CSUM);
        cpu_hold_d = (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= IDLE;
            n_q        <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
            asm_q      <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            rx_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            csum_q     <= csum_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
            rx_ready_q <= rx_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed testbench for prog_loader. Each scenario task drives a byte stream
// and compares the outputs against hand-computed values. A monitor records
// every write strobe so the write sequence can be checked per scenario.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int passed = 0;

    logic [7:0]  wa_log[$];
    logic [31:0] wd_log[$];
    logic [7:0]  stream[$];

    prog_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Record writes on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_log.push_back(waddr);
            wd_log.push_back(wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa_log.delete();
        wd_log.delete();
    endtask

    // Present one byte until it is taken; waits = cycles spent stalled
    task automatic send_byte(input logic [7:0] b, output int waits);
        waits    = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && waits < 50) begin
            tick();
            waits++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            $display("FAIL send_timeout: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
        end else begin
            tick();
        end
        rx_valid = 1'b0;
        rx_data  = 8'hxx;
    endtask

    // Send the stream queue; gappy inserts idle cycles with junk on rx_data
    task automatic send_stream(input bit gappy);
        int w;
        for (int i = 0; i < stream.size(); i++) begin
            if (gappy) begin
                int gap;
                gap = $urandom_range(0, 3) + ((i % 2) == 1 ? 1 : 0);
                for (int g = 0; g < gap; g++) begin
                    rx_valid = 1'b0;
                    rx_data  = 8'($urandom);
                    tick();
                end
            end
            send_byte(stream[i], w);
        end
    endtask

    task automatic nominal_stream(input logic [7:0] cs);
        stream.delete();
        stream = '{8'h02, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00,
                   8'hB7, 8'h00, 8'h00, 8'h00};
        stream.push_back(cs);
    endtask

    task automatic check_nominal_writes(input string tag);
        checks++;
        if (wa_log.size() !== 2) begin
            $display("FAIL %s_wcount: got %0d writes, required 2", tag, wa_log.size());
        end else begin
            passed++;
            checks++;
            if (wa_log[0] !== 8'd0 || wd_log[0] !== 32'h00000037)
                $display("FAIL %s_w0: got (%h,%h) required (00,00000037)", tag, wa_log[0], wd_log[0]);
            else passed++;
            checks++;
            if (wa_log[1] !== 8'd1 || wd_log[1] !== 32'h000000B7)
                $display("FAIL %s_w1: got (%h,%h) required (01,000000b7)", tag, wa_log[1], wd_log[1]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        checks++;
        if ({rx_ready, we, cpu_hold, done, error} !== 5'b00100)
            $display("FAIL reset_ctrl: got rdy/we/hold/done/err=%b required 00100",
                     {rx_ready, we, cpu_hold, done, error});
        else passed++;
        checks++;
        if (waddr !== 8'd0 || wdata !== 32'd0)
            $display("FAIL reset_bus: got waddr=%h wdata=%h required 0/0", waddr, wdata);
        else passed++;
        clear = 1'b0; start = 1'b0;
        repeat (2) tick();
        checks++;
        if (rx_ready !== 1'b0 || cpu_hold !== 1'b1)
            $display("FAIL reset_idle: got rdy=%b hold=%b required 0/1", rx_ready, cpu_hold);
        else passed++;
    endtask

    task automatic test_nominal();
        int w;
        clear_log();
        do_start();
        checks++;
        if (rx_ready !== 1'b1)
            $display("FAIL nominal_ready_after_start: got %b required 1", rx_ready);
        else passed++;
        nominal_stream(8'hEE);
        for (int i = 0; i < 6; i++) send_byte(stream[i], w);
        // cycle after the first lane-3 transfer
        checks++;
        if (we !== 1'b1 || waddr !== 8'd0 || wdata !== 32'h00000037 || rx_ready !== 1'b1)
            $display("FAIL nominal_we0_timing: got we=%b waddr=%h wdata=%h rdy=%b required 1/00/00000037/1",
                     we, waddr, wdata, rx_ready);
        else passed++;
        for (int i = 6; i < 10; i++) send_byte(stream[i], w);
        // final write coincides with the first CSUM cycle; checksum accepted at once
        send_byte(stream[10], w);
        checks++;
        if (w !== 0)
            $display("FAIL nominal_csum_bubble: got %0d stall cycles required 0", w);
        else passed++;
        checks++;
        if ({done, error, cpu_hold, rx_ready} !== 4'b1000)
            $display("FAIL nominal_result: got done/err/hold/rdy=%b required 1000",
                     {done, error, cpu_hold, rx_ready});
        else passed++;
        tick();
        check_nominal_writes("nominal");
    endtask

    task automatic test_bad_csum();
        clear_log();
        do_start();
        checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1)
            $display("FAIL badcs_restart: got done=%b hold=%b required 0/1", done, cpu_hold);
        else passed++;
        nominal_stream(8'hEF);
        send_stream(1'b0);
        checks++;
        if ({done, error, cpu_hold, rx_ready} !== 4'b0110)
            $display("FAIL badcs_result: got done/err/hold/rdy=%b required 0110",
                     {done, error, cpu_hold, rx_ready});
        else passed++;
        tick();
        check_nominal_writes("badcs");
        do_start();
        checks++;
        if (rx_ready !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b1)
            $display("FAIL badcs_reenter: got rdy=%b err=%b hold=%b required 1/0/1",
                     rx_ready, error, cpu_hold);
        else passed++;
    endtask

    task automatic test_overflow();
        int w;
        // loader is in LEN0 here; this start must be ignored
        clear_log();
        do_start();
        send_byte(8'h01, w);
        send_byte(8'h01, w);
        checks++;
        if (error !== 1'b1 || rx_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL ovf_err: got err=%b rdy=%b done=%b required 1/0/0", error, rx_ready, done);
        else passed++;
        repeat (2) tick();
        checks++;
        if (wa_log.size() !== 0)
            $display("FAIL ovf_nowrite: got %0d writes required 0", wa_log.size());
        else passed++;
        do_start();
        send_byte(8'h00, w);
        send_byte(8'h00, w);
        checks++;
        if (rx_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL zero_csum_wait: got rdy=%b done=%b required 1/0", rx_ready, done);
        else passed++;
        send_byte(8'h00, w);
        tick();
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || wa_log.size() !== 0)
            $display("FAIL zero_done: got done=%b hold=%b writes=%0d required 1/0/0",
                     done, cpu_hold, wa_log.size());
        else passed++;
    endtask

    task automatic test_full_depth();
        logic [7:0] cs;
        cs = 8'h00;
        clear_log();
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h01);
        for (int i = 0; i < 256; i++) begin
            stream.push_back(8'(i));
            stream.push_back(8'h00);
            stream.push_back(8'hA5);
            stream.push_back(8'h00);
            cs = cs + 8'(i) + 8'hA5;
        end
        stream.push_back(cs);
        do_start();
        send_stream(1'b0);
        tick();
        checks++;
        if (done !== 1'b1 || error !== 1'b0)
            $display("FAIL full_result: got done=%b err=%b required 1/0", done, error);
        else passed++;
        checks++;
        if (wa_log.size() !== 256) begin
            $display("FAIL full_wcount: got %0d required 256", wa_log.size());
        end else begin
            passed++;
            checks++;
            if (wa_log[255] !== 8'd255 || wd_log[255] !== 32'h00A500FF)
                $display("FAIL full_last: got (%h,%h) required (ff,00a500ff)", wa_log[255], wd_log[255]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        do_start();
        nominal_stream(8'hEE);
        send_stream(1'b1);
        tick();
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0)
            $display("FAIL bp_result: got done=%b hold=%b err=%b required 1/0/0", done, cpu_hold, error);
        else passed++;
        check_nominal_writes("bp");
        // bytes offered in DONE are not consumed
        rx_valid = 1'b1;
        rx_data  = 8'h13;
        repeat (3) tick();
        rx_valid = 1'b0;
        checks++;
        if (wa_log.size() !== 2 || done !== 1'b1 || rx_ready !== 1'b0)
            $display("FAIL bp_done_ignore: got writes=%0d done=%b rdy=%b required 2/1/0",
                     wa_log.size(), done, rx_ready);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int w;
        do_start();
        nominal_stream(8'hEE);
        for (int i = 0; i < 8; i++) send_byte(stream[i], w);  // N + 6 payload bytes
        clear_log();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({rx_ready, we, cpu_hold, done} !== 4'b0010 || waddr !== 8'd0)
            $display("FAIL mid_clear: got rdy/we/hold/done=%b waddr=%h required 0010/00",
                     {rx_ready, we, cpu_hold, done}, waddr);
        else passed++;
        repeat (4) tick();
        checks++;
        if (wa_log.size() !== 0)
            $display("FAIL mid_nowrite: got %0d writes required 0", wa_log.size());
        else passed++;
        do_start();
        send_stream(1'b0);
        tick();
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0)
            $display("FAIL mid_reload: got done=%b hold=%b required 1/0", done, cpu_hold);
        else passed++;
        check_nominal_writes("mid");
        // start in DONE re-asserts cpu_hold the next cycle
        do_start();
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1)
            $display("FAIL done_restart: got hold=%b done=%b rdy=%b required 1/0/1",
                     cpu_hold, done, rx_ready);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_csum();
        test_overflow();
        test_full_depth();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the single-cycle RISC-V core. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written through the instruction memory's write port, and the CPU is held in reset (`cpu_hold`) until a complete, checksum-verified image is resident. It is the write-side counterpart of the instruction memory's combinational read port. The block sits between the host byte source (UART receiver or testbench) and the instruction memory.

## Interface

- `DEPTH`, 256: instruction memory depth in 32-bit words.
- `ADDR_W`, 8: word-address width, `log2(DEPTH)`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERR.
- `rx_data`  in  8  byte from the host stream.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle. A transfer occurs when `rx_valid && rx_ready`.
- `we`  out  1  instruction memory write strobe, one cycle per word.
- `waddr`  out  `ADDR_W`  word address of the write.
- `wdata`  out  32  instruction word.
- `cpu_hold`  out  1  holds the CPU in reset; low only in DONE.
- `done`  out  1  image loaded and checksum matched; sticky.
- `error`  out  1  length overflow or checksum mismatch; sticky.

## Operation

- Stream format, in order:
  - N low byte, then N high byte (N = 16-bit word count).
  - 4·N payload bytes, least-significant byte of each word first.
  - One checksum byte equal to the sum of all payload bytes mod 256.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE:
  - `rx_ready`=0.
  - `start` moves to LEN0 and clears the byte counter, word counter, checksum accumulator, `done` and `error`.
- LEN0:
  - `rx_ready`=1.
  - A transfer stores N[7:0] and moves to LEN1.
- LEN1:
  - `rx_ready`=1.
  - A transfer stores N[15:8], then:
    - N > DEPTH → ERR.
    - N == 0 → CSUM.
    - Otherwise → DATA.
- DATA:
  - `rx_ready`=1.
  - Each transfer places the byte in lane `byte_cnt` (0..3) of the assembly register and adds it to the 8-bit checksum.
  - On the lane-3 transfer, the assembled word (including that byte) is copied into the `wdata` register, `waddr` ← word_cnt, and `we` is asserted the next cycle.
  - After lane 3, word_cnt increments. When word_cnt reaches N → CSUM.
- CSUM:
  - `rx_ready`=1.
  - A transfer compares the byte with the accumulator: equal → DONE (`done`=1), unequal → ERR (`error`=1).
- DONE:
  - `cpu_hold`=0, `rx_ready`=0.
  - `start` restarts the load at LEN0 and re-asserts `cpu_hold` the next cycle.
- ERR:
  - `cpu_hold`=1, `rx_ready`=0.
  - `start` restarts the load at LEN0.
- `start` in LEN0, LEN1, DATA or CSUM is ignored.
- `clear` overrides everything, including a coincident `start`, and returns to IDLE.
- Word addresses always start at 0 and are contiguous. The word counter never wraps because N ≤ DEPTH is checked before DATA.
- Bytes presented while `rx_ready`=0 are not consumed. The loader never drops or duplicates bytes.

## Timing

- Reset values: `rx_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, FSM=IDLE.
- `start` sampled in cycle t → `rx_ready`=1 in t+1.
- `we` is a registered single-cycle pulse in the cycle after the lane-3 transfer. `waddr` and `wdata` are stable that cycle and hold until the next write.
- `rx_ready` stays high during the `we` cycle, so back-to-back bytes are accepted with no bubble. The `wdata` register is separate from the assembly register.
- Final-word `we` and the first CSUM-state cycle coincide. A checksum byte arriving in that cycle is accepted.
- `done` or `error` asserts in the cycle after the checksum transfer. `cpu_hold` deasserts in that same cycle on success.
- All outputs are registered; there are no combinational paths from `rx_valid` to `rx_ready`.

## Test plan

- Reset: hold `clear`=1 for 3 cycles with `start`=1 → state IDLE, `cpu_hold`=1, `rx_ready`=0, `we`=0, `done`=`error`=0.
- Nominal load: `start`, then bytes 02 00 37 00 00 00 B7 00 00 00 EE → writes (0, 0x00000037) then (1, 0x000000B7), one `we` pulse each; `done`=1, `cpu_hold`=0 one cycle after EE.
- Bad checksum: same stream with EF as the last byte → both writes occur, `error`=1, `done`=0, `cpu_hold` stays 1; a following `start` re-enters LEN0.
- Overflow: N bytes 01 01 (257) → ERR after the second byte, `rx_ready`=0, no `we`. N=00 00 followed by checksum 00 → `done`=1 with no writes.
- Backpressure/gaps: nominal stream with `rx_valid` toggled every other cycle and random idle gaps → identical writes and result, no byte lost.
- Reset mid-load: assert `clear` after the 6th payload byte → IDLE next cycle, no further `we`, `waddr`=0, `cpu_hold`=1; a restarted full load then succeeds.
